// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-bit two-flop synchronizer, debounce filter,
// direction-gated edge pulses and a sticky pending-event mask handed to a
// consumer through a valid/ready acknowledge.
module gpio_in_conditioner #(
    parameter int GPIO_NUMBER = 32,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [GPIO_NUMBER-1:0] pad_i,
    input  logic [GPIO_NUMBER-1:0] dir_i,
    input  logic [DEBOUNCE_W-1:0]  debounce_limit_i,
    input  logic [GPIO_NUMBER-1:0] rise_en_i,
    input  logic [GPIO_NUMBER-1:0] fall_en_i,
    output logic [GPIO_NUMBER-1:0] gpio_o,
    output logic [GPIO_NUMBER-1:0] rise_o,
    output logic [GPIO_NUMBER-1:0] fall_o,
    output logic                   event_valid_o,
    output logic [GPIO_NUMBER-1:0] event_mask_o,
    input  logic                   event_ready_i
);

    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = DEBOUNCE_W'(1);

    logic [GPIO_NUMBER-1:0] sync0_q, sync0_d;
    logic [GPIO_NUMBER-1:0] sync1_q, sync1_d;
    logic [GPIO_NUMBER-1:0] stable_q, stable_d;
    logic [GPIO_NUMBER-1:0] stable_dly_q, stable_dly_d;
    logic [GPIO_NUMBER-1:0] pending_q, pending_d;
    logic [DEBOUNCE_W-1:0]  cnt_q [GPIO_NUMBER];
    logic [DEBOUNCE_W-1:0]  cnt_d [GPIO_NUMBER];
    logic [GPIO_NUMBER-1:0] rise_w, fall_w, new_ev;
    logic                   valid_w;

    // Debounce: a mismatch must persist past L counted cycles before it is
    // committed. The compare is >= so a limit lowered below a running count
    // commits on the next mismatch instead of wrapping.
    always_comb begin
        sync0_d      = pad_i;
        sync1_d      = sync0_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        for (int i = 0; i < GPIO_NUMBER; i++) begin
            cnt_d[i] = '0;
            if (sync1_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= debounce_limit_i) begin
                    stable_d[i] = sync1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Edge pulses are gated by the current direction; outputs are forced low
    // while reset is held so nothing leaks before the first reset edge.
    always_comb begin
        rise_w  = rst_n ? (stable_q & ~stable_dly_q & ~dir_i) : '0;
        fall_w  = rst_n ? (~stable_q & stable_dly_q & ~dir_i) : '0;
        valid_w = rst_n & (|pending_q);
        new_ev  = (rise_w & rise_en_i) | (fall_w & fall_en_i);
    end

    // Pending mask: an acknowledge clears old bits but keeps any edge that
    // arrives in the same cycle.
    always_comb begin
        if (valid_w && event_ready_i) begin
            pending_d = new_ev;
        end else begin
            pending_d = pending_q | new_ev;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0_q      <= '0;
            sync1_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            pending_q    <= '0;
            for (int i = 0; i < GPIO_NUMBER; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync0_q      <= sync0_d;
            sync1_q      <= sync1_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            pending_q    <= pending_d;
            for (int i = 0; i < GPIO_NUMBER; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Output drive; gpio_o reports the filtered level for every bit.
    always_comb begin
        gpio_o        = rst_n ? stable_q : '0;
        rise_o        = rise_w;
        fall_o        = fall_w;
        event_valid_o = valid_w;
        event_mask_o  = rst_n ? pending_q : '0;
    end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench for gpio_in_conditioner: stimulus pushes each expected
// output snapshot with the clock edge after which it must appear; a monitor
// pops and compares whenever the DUT outputs change.
module tb_gpio_in_conditioner;

    localparam int N = 8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] pad_i = '0;
    logic [N-1:0] dir_i = '0;
    logic [W-1:0] debounce_limit_i = 8'd4;
    logic [N-1:0] rise_en_i = '1;
    logic [N-1:0] fall_en_i = '1;
    logic         event_ready_i = 1'b0;
    logic [N-1:0] gpio_o, rise_o, fall_o, event_mask_o;
    logic         event_valid_o;

    gpio_in_conditioner #(.GPIO_NUMBER(N), .DEBOUNCE_W(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pad_i            (pad_i),
        .dir_i            (dir_i),
        .debounce_limit_i (debounce_limit_i),
        .rise_en_i        (rise_en_i),
        .fall_en_i        (fall_en_i),
        .gpio_o           (gpio_o),
        .rise_o           (rise_o),
        .fall_o           (fall_o),
        .event_valid_o    (event_valid_o),
        .event_mask_o     (event_mask_o),
        .event_ready_i    (event_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        logic [32:0] snap;
    } exp_t;

    exp_t        exp_q[$];
    int          edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [32:0] prev_snap = '0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // {gpio, rise, fall, valid, mask}
    function automatic logic [32:0] pack(input logic [7:0] g, input logic [7:0] r,
                                         input logic [7:0] f, input logic v,
                                         input logic [7:0] m);
        return {g, r, f, v, m};
    endfunction

    task automatic expect_out(input int at, input logic [7:0] g, input logic [7:0] r,
                              input logic [7:0] f, input logic v, input logic [7:0] m);
        exp_t e;
        e.edge_n = at;
        e.snap   = pack(g, r, f, v, m);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: any change of the output bundle is one DUT presentation.
    always @(negedge clk) begin
        logic [32:0] cur;
        exp_t        e;
        cur = pack(gpio_o, rise_o, fall_o, event_valid_o, event_mask_o);
        if (cur !== prev_snap) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output edge=%0d got=%h expected no change", edge_cnt, cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.snap || edge_cnt != e.edge_n) begin
                    errors++;
                    $display("FAIL output_change got=%h@edge%0d expected=%h@edge%0d",
                             cur, edge_cnt, e.snap, e.edge_n);
                end
            end
        end
        prev_snap = cur;
    end

    initial begin
        int e;
        tick(3);
        @(negedge clk);
        checks++;
        if ({gpio_o, rise_o, fall_o, event_valid_o, event_mask_o} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {gpio_o, rise_o, fall_o, event_valid_o, event_mask_o});
        end
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Persistent rise on bit 0, L=4: filtered at e+7, event one edge later.
        e = edge_cnt; pad_i[0] = 1'b1;
        expect_out(e + 7, 8'h01, 8'h01, 8'h00, 1'b0, 8'h00);
        expect_out(e + 8, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01);
        tick(10);

        // Bit 3 rises while 0x1 is held: mask accumulates to 0x9.
        e = edge_cnt; pad_i[3] = 1'b1;
        expect_out(e + 7, 8'h09, 8'h08, 8'h00, 1'b1, 8'h01);
        expect_out(e + 8, 8'h09, 8'h00, 8'h00, 1'b1, 8'h09);
        tick(10);
        e = edge_cnt; event_ready_i = 1'b1;
        expect_out(e + 1, 8'h09, 8'h00, 8'h00, 1'b0, 8'h00);
        tick(1); event_ready_i = 1'b0;
        tick(4);

        // Glitches on bit 5 of 3 and of exactly L=4 cycles are rejected.
        pad_i[5] = 1'b1; tick(3); pad_i[5] = 1'b0; tick(10);
        pad_i[5] = 1'b1; tick(4); pad_i[5] = 1'b0; tick(10);

        // L+1 cycle pulse on bit 6 passes, then its fall follows.
        e = edge_cnt; pad_i[6] = 1'b1;
        expect_out(e + 7,  8'h49, 8'h40, 8'h00, 1'b0, 8'h00);
        expect_out(e + 8,  8'h49, 8'h00, 8'h00, 1'b1, 8'h40);
        expect_out(e + 12, 8'h09, 8'h00, 8'h40, 1'b1, 8'h40);
        expect_out(e + 13, 8'h09, 8'h00, 8'h00, 1'b1, 8'h40);
        tick(5); pad_i[6] = 1'b0;
        tick(12);
        e = edge_cnt; event_ready_i = 1'b1;
        expect_out(e + 1, 8'h09, 8'h00, 8'h00, 1'b0, 8'h00);
        tick(1); event_ready_i = 1'b0;
        tick(4);

        // Pending 0x2, then acknowledge in the cycle bit 7 fires.
        e = edge_cnt; pad_i[1] = 1'b1;
        expect_out(e + 7, 8'h0B, 8'h02, 8'h00, 1'b0, 8'h00);
        expect_out(e + 8, 8'h0B, 8'h00, 8'h00, 1'b1, 8'h02);
        tick(10);
        e = edge_cnt; pad_i[7] = 1'b1;
        expect_out(e + 7, 8'h8B, 8'h80, 8'h00, 1'b1, 8'h02);
        expect_out(e + 8, 8'h8B, 8'h00, 8'h00, 1'b1, 8'h80);
        tick(7); event_ready_i = 1'b1;
        tick(1); event_ready_i = 1'b0;
        tick(4);
        e = edge_cnt; event_ready_i = 1'b1;
        expect_out(e + 1, 8'h8B, 8'h00, 8'h00, 1'b0, 8'h00);
        tick(1); event_ready_i = 1'b0;
        tick(4);

        // Output-direction bit 2 with L=0: level follows in 3 edges, no pulses.
        e = edge_cnt; debounce_limit_i = 8'd0; dir_i = 8'h04; pad_i[2] = 1'b1;
        expect_out(e + 3, 8'h8F, 8'h00, 8'h00, 1'b0, 8'h00);
        tick(6);
        e = edge_cnt; pad_i[2] = 1'b0;
        expect_out(e + 3, 8'h8B, 8'h00, 8'h00, 1'b0, 8'h00);
        tick(6);

        // Invert every bit: four rises and four falls give pending 0xFF.
        e = edge_cnt; dir_i = 8'h00; debounce_limit_i = 8'd4; pad_i = 8'h74;
        expect_out(e + 7, 8'h74, 8'h74, 8'h8B, 1'b0, 8'h00);
        expect_out(e + 8, 8'h74, 8'h00, 8'h00, 1'b1, 8'hFF);
        tick(10);

        // Reset for one edge mid-count with 0xFF pending.
        pad_i = 8'h00;
        tick(4);
        e = edge_cnt; rst_n = 1'b0;
        expect_out(e, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        tick(1); rst_n = 1'b1;
        tick(2);

        // Bit 2 counted twice before reset; full latency proves cnt restarted.
        e = edge_cnt; pad_i = 8'h04;
        expect_out(e + 7, 8'h04, 8'h04, 8'h00, 1'b0, 8'h00);
        expect_out(e + 8, 8'h04, 8'h00, 8'h00, 1'b1, 8'h04);
        tick(14);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs got=%0d unseen expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 SHALL have parameter GPIO_NUMBER, default 32: number of GPIO lines handled.
REQ-002 SHALL have parameter DEBOUNCE_W, default 16: width of the debounce counter and limit.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port pad_i, input, GPIO_NUMBER, raw asynchronous pad levels from the GPIO inout buffers.
REQ-006 SHALL have port dir_i, input, GPIO_NUMBER, per-bit direction: 0 = input, 1 = output.
REQ-007 SHALL have port debounce_limit_i, input, DEBOUNCE_W, debounce limit L, quasi-static.
REQ-008 SHALL have port rise_en_i, input, GPIO_NUMBER, per-bit rising-edge event enable.
REQ-009 SHALL have port fall_en_i, input, GPIO_NUMBER, per-bit falling-edge event enable.
REQ-010 SHALL have port gpio_o, output, GPIO_NUMBER, filtered level that drives the SoC gpio_in.
REQ-011 SHALL have port rise_o, output, GPIO_NUMBER, one-cycle pulse on each filtered 0->1 transition of an input bit.
REQ-012 SHALL have port fall_o, output, GPIO_NUMBER, one-cycle pulse on each filtered 1->0 transition of an input bit.
REQ-013 SHALL have port event_valid_o, output, 1, high while any pending event bit is set.
REQ-014 SHALL have port event_mask_o, output, GPIO_NUMBER, the pending event bits.
REQ-015 SHALL have port event_ready_i, input, 1, consumer acknowledge.

Function
REQ-016 Each bit SHALL pass through a 2-flop synchronizer: sync0 <= pad_i, sync1 <= sync0.
REQ-017 Each bit SHALL hold a stable register and a DEBOUNCE_W-bit counter cnt.
REQ-018 When sync1 == stable, cnt SHALL load 0.
REQ-019 When sync1 != stable and cnt == L, stable SHALL load sync1 and cnt SHALL load 0.
REQ-020 When sync1 != stable and cnt != L, cnt SHALL increment by 1; it cannot overflow because it stops at L.
REQ-021 gpio_o SHALL equal stable for every bit, regardless of dir_i.
REQ-022 The latency from a pad change that persists, present before edge k, to gpio_o SHALL be L+3 edges: gpio_o updates at edge k+2+L.
REQ-023 A pad pulse whose synchronized width is at most L cycles SHALL be rejected, with no change on gpio_o.
REQ-024 L = 0 SHALL bypass filtering, so stable follows sync1 one cycle later.
REQ-025 rise_o[i] SHALL pulse for exactly one cycle, in the cycle after stable[i] goes 0->1, only if dir_i[i] == 0 in that cycle.
REQ-026 fall_o[i] SHALL follow the same rule as REQ-025 for a 1->0 transition of stable[i].
REQ-027 new_ev SHALL be defined as (rise_o & rise_en_i) | (fall_o & fall_en_i).
REQ-028 When event_valid_o is 0 or event_ready_i is 0, pending SHALL load pending | new_ev.
REQ-029 When event_valid_o and event_ready_i are both 1, pending SHALL load new_ev, so an edge arriving in the acknowledge cycle is never lost.
REQ-030 event_mask_o SHALL equal pending, and event_valid_o SHALL equal the OR-reduction of pending.
REQ-031 event_mask_o SHALL be stable while event_valid_o is 1 and event_ready_i is 0, except for bits newly OR-ed in.
REQ-032 Changing dir_i, rise_en_i or fall_en_i SHALL NOT clear pending bits; it SHALL only gate new events.
REQ-033 Changing L mid-count SHALL take effect on the next compare, with no reset of cnt; if cnt > new L, the counter SHALL commit on the next mismatch cycle (compare is cnt >= L).

Reset
REQ-034 While rst_n is 0 at a clock edge, sync0, sync1, stable, cnt and pending SHALL all load 0.
REQ-035 While rst_n is 0, the outputs SHALL be gpio_o = 0, rise_o = 0, fall_o = 0, event_valid_o = 0 and event_mask_o = 0.
REQ-036 After reset, a pad that is already high SHALL produce one filtered rising edge after the REQ-022 latency, and an event if enabled.
REQ-037 Reset asserted mid-count or with events pending SHALL discard all state on that edge.

Verification
REQ-038 L=4, rise_en=1 on bit 0, pad_i[0] 0->1 before edge 0: gpio_o[0] rises after edge 6, rise_o[0] is high for one cycle, event_valid_o=1 and event_mask_o=0x1.
REQ-039 L=4, 3-cycle high glitch on pad_i[5]: gpio_o[5] stays 0, with no pulses and no events.
REQ-040 Pending 0x1 held with ready=0, then bit 3 rises: event_mask_o=0x9; ready=1 for one cycle gives event_valid_o=0 next cycle.
REQ-041 Ready=1 in the same cycle bit 7 fires, with pending=0x2: the next event_mask_o is 0x80 and event_valid_o stays 1.
REQ-042 dir_i[2]=1, pad_i[2] toggles with L=0: gpio_o[2] follows after 3 edges, rise_o[2] and fall_o[2] stay 0, and there are no events.
REQ-043 rst_n=0 for one edge during counting with pending=0xFF: all outputs are 0 on the next cycle, and filtering restarts from cnt=0.
